icache_lite: RTL and testbench
==============================

Name: icache_lite

Overview:
- Direct-mapped, read-only instruction cache. Responds to the fetch unit's 64-bit fetch requests.
- Sits between the core frontend (fetch-side icache_* interface) and a simple line-refill memory read port.
- Hits return two instructions one cycle after accept. Misses stall acceptance while a 4-beat line refill is performed.

Parameters:
- NUM_LINES, 64, number of cache lines (power of two).
- NUM_LINES_W, 6, log2(NUM_LINES).

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  asynchronous active-low reset
- icache_rd_i  input  1  fetch request valid
- icache_pc_i  input  32  fetch PC; bits [2:0] ignored (64-bit aligned)
- icache_priv_i  input  2  fetch privilege; unused in this non-MMU variant
- icache_flush_i  input  1  pulse: invalidate all lines
- icache_invalidate_i  input  1  pulse: invalidate all lines (same action as flush)
- icache_accept_o  output  1  request accepted this cycle
- icache_valid_o  output  1  response valid (single-cycle pulse)
- icache_inst_o  output  64  instruction pair; [31:0] = PC+0, [63:32] = PC+4
- icache_error_o  output  1  bus error on the refill for this response
- icache_page_fault_o  output  1  constant 0
- mem_req_o  output  1  line refill request
- mem_addr_o  output  32  line-aligned refill address ([4:0] = 0)
- mem_accept_i  input  1  refill request accepted
- mem_valid_i  input  1  refill data beat valid
- mem_data_i  input  64  refill beat data
- mem_error_i  input  1  error on this beat
- mem_last_i  input  1  final (4th) beat

Behaviour:
- Geometry: 32-byte lines, 4 beats of 64 bits.
  - offset = pc[4:3]
  - index = pc[5+NUM_LINES_W-1:5]
  - tag = pc[31:5+NUM_LINES_W]
- Storage:
  - Tag and valid bits are held in flops.
  - Data array is NUM_LINES*4 x 64 with synchronous read.
- Reset:
  - All valid bits cleared.
  - State = LOOKUP.
  - All outputs 0, including icache_inst_o.
  - Reset during a refill abandons it; the memory side is reset together with this block.
- States:
  - LOOKUP
  - REFILL_REQ
  - REFILL_DATA
  - RESPOND
  - FLUSH
- LOOKUP:
  - icache_accept_o = icache_rd_i && !flush_pending && !(pending_q && miss).
  - An accepted request registers pc into pending_q and starts the data read.
  - In the cycle after accept, the tag is compared:
    - Hit: icache_valid_o=1 and icache_inst_o=data. A new request may be accepted in the same cycle, giving 1 response/cycle throughput.
    - Miss: no valid, accept=0, next state REFILL_REQ.
- REFILL_REQ:
  - mem_req_o=1, mem_addr_o={pending pc[31:5],5'b0}.
  - Held until mem_accept_i=1, then go to REFILL_DATA.
- REFILL_DATA:
  - Each mem_valid_i writes beat k (k=0..3, incrementing from the line base) into the data array.
  - The beat with k==offset is captured as the response word.
  - mem_error_i on any beat sets a sticky error flag.
  - On mem_last_i go to RESPOND.
    - If there was no error: write the tag and set the valid bit.
    - If there was an error: clear the valid bit for that index.
- RESPOND:
  - One cycle with icache_valid_o=1.
  - inst = captured word; error = sticky flag. On error, inst_o = 0.
  - Then go to FLUSH if flush_pending, else LOOKUP.
  - Miss latency: response arrives exactly 1 cycle after the mem_last_i beat.
- Flush/invalidate:
  - Either pulse sets flush_pending; pulses arriving while flush_pending is already set are absorbed.
  - From LOOKUP, enter FLUSH the next cycle. Any hit already pending in that cycle is still delivered.
  - During REFILL_*, the flush is deferred until after RESPOND; the refill response is still delivered.
  - FLUSH clears one valid bit per cycle using an index counter: NUM_LINES cycles, accept=0 throughout.
  - Then clear flush_pending and return to LOOKUP.
  - A flush pulse arriving during FLUSH restarts the counter at 0.
- Simultaneous events:
  - A flush pulse in the same cycle as icache_rd_i: the request is not accepted.
- Wrap-around:
  - PC 0xFFFF_FFF8 is a normal beat 3 of the last line.
  - Index and beat counters wrap modulo their width.
- Memory-side handshake rules:
  - mem_valid_i outside REFILL_DATA is ignored.
  - mem_last_i is assumed coincident with the 4th beat.

Test Plan:
- Cold miss: request pc=0x8000_0008 → mem_req_o with mem_addr_o=0x8000_0000; beats D0..D3 returned; valid_o=1 with inst_o=D1 exactly 1 cycle after the last beat; accept_o=0 throughout the refill.
- Hits back-to-back: after the previous refill, requests 0x8000_0000, 0x8000_0010, 0x8000_0018 on consecutive cycles → accept every cycle; valid_o on the following 3 cycles with D0, D2, D3; no mem_req_o.
- Conflict eviction (NUM_LINES=64): access 0x8000_0000 then 0x8000_0800 (same index) → both miss. Re-access 0x8000_0000 → miss again, refill address 0x8000_0000.
- Refill error: mem_error_i on beat 2 of a refill for 0x8000_0000 → valid_o=1, error_o=1, inst_o=0. A re-request of the same PC misses again.
- Flush during refill: pulse icache_flush_i mid-REFILL_DATA → refill response still delivered, then 64 cycles with accept_o=0. After that, 0x8000_0000 misses.
- Reset mid-refill: deassert rstn_i during REFILL_DATA → all outputs 0 immediately. After release, first access to the previously cached line misses.

Source files
------------

// File: rtl/icache_lite.sv
// Direct-mapped read-only instruction cache: 32-byte lines refilled as 4 x 64-bit beats,
// single-cycle hit response, refill-on-miss, and a walking whole-cache invalidate.
module icache_lite #(
  parameter int unsigned NUM_LINES   = 64,
  parameter int unsigned NUM_LINES_W = 6
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        icache_rd_i,
  input  logic [31:0] icache_pc_i,
  input  logic [1:0]  icache_priv_i,
  input  logic        icache_flush_i,
  input  logic        icache_invalidate_i,
  output logic        icache_accept_o,
  output logic        icache_valid_o,
  output logic [63:0] icache_inst_o,
  output logic        icache_error_o,
  output logic        icache_page_fault_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [63:0] mem_data_i,
  input  logic        mem_error_i,
  input  logic        mem_last_i
);

  localparam int unsigned TAG_W  = 32 - 5 - NUM_LINES_W;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [2:0] {
    LOOKUP,
    REFILL_REQ,
    REFILL_DATA,
    RESPOND,
    FLUSH
  } state_t;

  state_t                   state;
  logic                     ready_q;
  logic                     miss_q;
  logic                     flush_pending_q;
  logic [31:3]              pending_pc_q;
  logic [NUM_LINES_W-1:0]   flush_idx_q;
  logic [1:0]               beat_q;
  logic                     err_q;
  logic [DATA_W-1:0]        capture_q;
  logic [NUM_LINES-1:0]     valid_q;
  logic [TAG_W-1:0]         tag_q [NUM_LINES];
  logic [DATA_W-1:0]        data_mem [NUM_LINES*4];

  logic [NUM_LINES_W-1:0]   req_idx;
  logic [TAG_W-1:0]         req_tag;
  logic [NUM_LINES_W-1:0]   pend_idx;
  logic [TAG_W-1:0]         pend_tag;
  logic [1:0]               pend_off;
  logic                     flush_in;
  logic                     hit_c;
  logic                     accept_c;
  logic                     beat_we;
  logic                     err_now;
  logic                     unused_bits;

  assign req_idx  = icache_pc_i[5+NUM_LINES_W-1:5];
  assign req_tag  = icache_pc_i[31:5+NUM_LINES_W];
  assign pend_idx = pending_pc_q[5+NUM_LINES_W-1:5];
  assign pend_tag = pending_pc_q[31:5+NUM_LINES_W];
  assign pend_off = pending_pc_q[4:3];
  assign flush_in = icache_flush_i | icache_invalidate_i;
  assign beat_we  = (state == REFILL_DATA) && mem_valid_i;
  assign err_now  = err_q | mem_error_i;

  // Tag compare happens against the flops at accept time; the registered result
  // lines up with the synchronous data read one cycle later.
  assign hit_c    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept_c = ready_q && (state == LOOKUP) && icache_rd_i &&
                    !flush_pending_q && !flush_in && !miss_q;

  assign icache_accept_o     = accept_c;
  assign icache_page_fault_o = 1'b0;
  assign unused_bits         = ^{icache_priv_i, icache_pc_i[2:0]};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state           <= LOOKUP;
      ready_q         <= 1'b0;
      miss_q          <= 1'b0;
      flush_pending_q <= 1'b0;
      pending_pc_q    <= '0;
      flush_idx_q     <= '0;
      beat_q          <= '0;
      err_q           <= 1'b0;
      capture_q       <= '0;
      valid_q         <= '0;
      icache_valid_o  <= 1'b0;
      icache_inst_o   <= '0;
      icache_error_o  <= 1'b0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
    end else begin
      ready_q        <= 1'b1;
      icache_valid_o <= 1'b0;
      icache_error_o <= 1'b0;
      miss_q         <= 1'b0;

      if (flush_in) begin
        flush_pending_q <= 1'b1;
      end

      if (accept_c) begin
        pending_pc_q   <= icache_pc_i[31:3];
        icache_inst_o  <= data_mem[{req_idx, icache_pc_i[4:3]}];
        icache_valid_o <= hit_c;
        miss_q         <= !hit_c;
      end

      case (state)
        LOOKUP: begin
          flush_idx_q <= '0;
          if (miss_q) begin
            state      <= REFILL_REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {pending_pc_q[31:5], 5'b0};
          end else if (flush_in || flush_pending_q) begin
            state <= FLUSH;
          end
        end

        REFILL_REQ: begin
          if (mem_accept_i) begin
            state      <= REFILL_DATA;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
          end
        end

        REFILL_DATA: begin
          if (mem_valid_i) begin
            beat_q <= beat_q + 2'd1;
            err_q  <= err_now;
            if (beat_q == pend_off) begin
              capture_q <= mem_data_i;
            end
            if (mem_last_i) begin
              state             <= RESPOND;
              icache_valid_o    <= 1'b1;
              icache_error_o    <= err_now;
              valid_q[pend_idx] <= !err_now;
              if (err_now) begin
                icache_inst_o <= '0;
              end else if (beat_q == pend_off) begin
                icache_inst_o <= mem_data_i;
              end else begin
                icache_inst_o <= capture_q;
              end
            end
          end
        end

        RESPOND: begin
          flush_idx_q <= '0;
          state       <= (flush_pending_q || flush_in) ? FLUSH : LOOKUP;
        end

        FLUSH: begin
          // One line per cycle; a fresh pulse restarts the walk from line 0.
          valid_q[flush_idx_q] <= 1'b0;
          if (flush_in) begin
            flush_idx_q <= '0;
          end else if (flush_idx_q == NUM_LINES_W'(NUM_LINES - 1)) begin
            flush_pending_q <= 1'b0;
            state           <= LOOKUP;
          end else begin
            flush_idx_q <= flush_idx_q + NUM_LINES_W'(1);
          end
        end

        default: state <= LOOKUP;
      endcase
    end
  end

  // Data and tag storage carry no reset; the valid bits guard their contents.
  always_ff @(posedge clk_i) begin
    if (beat_we) begin
      data_mem[{pend_idx, beat_q}] <= mem_data_i;
      if (mem_last_i && !err_now) begin
        tag_q[pend_idx] <= pend_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_lite.sv
// Scoreboarded directed bench for icache_lite: refill data word = its own byte
// address, so every expected instruction pair is {pc+4, pc}.
module tb_icache_lite;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        icache_rd_i = 1'b0;
  logic [31:0] icache_pc_i = '0;
  logic [1:0]  icache_priv_i = 2'd3;
  logic        icache_flush_i = 1'b0;
  logic        icache_invalidate_i = 1'b0;
  logic        icache_accept_o;
  logic        icache_valid_o;
  logic [63:0] icache_inst_o;
  logic        icache_error_o;
  logic        icache_page_fault_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_accept_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [63:0] mem_data_i = '0;
  logic        mem_error_i = 1'b0;
  logic        mem_last_i = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q [$];
  logic [64:0] mon_e;
  logic [31:0] hit_pcs [3];

  icache_lite dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .icache_rd_i         (icache_rd_i),
    .icache_pc_i         (icache_pc_i),
    .icache_priv_i       (icache_priv_i),
    .icache_flush_i      (icache_flush_i),
    .icache_invalidate_i (icache_invalidate_i),
    .icache_accept_o     (icache_accept_o),
    .icache_valid_o      (icache_valid_o),
    .icache_inst_o       (icache_inst_o),
    .icache_error_o      (icache_error_o),
    .icache_page_fault_o (icache_page_fault_o),
    .mem_req_o           (mem_req_o),
    .mem_addr_o          (mem_addr_o),
    .mem_accept_i        (mem_accept_i),
    .mem_valid_i         (mem_valid_i),
    .mem_data_i          (mem_data_i),
    .mem_error_i         (mem_error_i),
    .mem_last_i          (mem_last_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input logic [31:0] pc);
    logic [31:0] a;
    a = {pc[31:3], 3'b0};
    return {a + 32'd4, a};
  endfunction

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk_i) begin
    if (rstn_i && icache_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got inst %h with nothing expected", icache_inst_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_inst", icache_inst_o, mon_e[63:0]);
        chk("resp_err", 64'(icache_error_o), 64'(mon_e[64]));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] pc);
    icache_rd_i = 1'b1;
    icache_pc_i = pc;
    @(negedge clk_i);
    chk("accept", 64'(icache_accept_o), 64'd1);
    tick();
    icache_rd_i = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] pc, output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL refill_req pc %h: mem_req_o stayed 0 for 20 cycles, required 1", pc);
    end else begin
      chk("refill_addr", 64'(mem_addr_o), 64'({pc[31:5], 5'b0}));
    end
  endtask

  // Serves a full line refill; err_beat outside 0..3 means a clean refill.
  task automatic refill(input logic [31:0] pc, input int err_beat, input bit flush_mid);
    logic [31:0] base;
    bit got;
    base = {pc[31:5], 5'b0};
    wait_req(pc, got);
    if (!got) return;
    mem_accept_i = 1'b1;
    tick();
    mem_accept_i = 1'b0;
    icache_rd_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_valid_i    = 1'b1;
      mem_data_i     = word(base + 32'(8 * k));
      mem_error_i    = (k == err_beat);
      mem_last_i     = (k == 3);
      icache_flush_i = flush_mid && (k == 1);
      if (k == 3) begin
        if (err_beat >= 0 && err_beat < 4) exp_q.push_back({1'b1, 64'd0});
        else exp_q.push_back({1'b0, word(pc)});
      end
      @(negedge clk_i);
      chk("accept_in_refill", 64'(icache_accept_o), 64'd0);
      tick();
    end
    icache_rd_i    = 1'b0;
    mem_valid_i    = 1'b0;
    mem_error_i    = 1'b0;
    mem_last_i     = 1'b0;
    icache_flush_i = 1'b0;
    @(negedge clk_i);
    chk("resp_latency", 64'(icache_valid_o), 64'd1);
  endtask

  // Holds a request and counts cycles refused before it is accepted.
  task automatic count_blocked(input logic [31:0] pc, input int required);
    int zeros;
    bit ok;
    zeros = 0;
    ok = 1'b0;
    icache_rd_i = 1'b1;
    icache_pc_i = pc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_i);
      if (icache_accept_o) begin
        ok = 1'b1;
        break;
      end
      zeros++;
      tick();
    end
    tick();
    icache_rd_i = 1'b0;
    chk("flush_blocked_cycles", 64'(zeros), 64'(required));
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL flush_end: accept_o never returned, required 1");
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 64'(icache_valid_o), 64'd0);
    chk({tag, "_inst"}, icache_inst_o, 64'd0);
    chk({tag, "_error"}, 64'(icache_error_o), 64'd0);
    chk({tag, "_memreq"}, 64'(mem_req_o), 64'd0);
    chk({tag, "_memaddr"}, 64'(mem_addr_o), 64'd0);
    chk({tag, "_accept"}, 64'(icache_accept_o), 64'd0);
    chk({tag, "_pf"}, 64'(icache_page_fault_o), 64'd0);
  endtask

  initial begin
    bit got;
    hit_pcs[0] = 32'h8000_0000;
    hit_pcs[1] = 32'h8000_0010;
    hit_pcs[2] = 32'h8000_0018;

    repeat (2) @(negedge clk_i);
    check_outputs_zero("reset");
    tick();
    rstn_i = 1'b1;
    tick();

    // Cold miss: response carries beat 1.
    req(32'h8000_0008);
    refill(32'h8000_0008, -1, 1'b0);
    tick();

    // Back-to-back hits on the refilled line.
    for (int i = 0; i < 3; i++) begin
      icache_rd_i = 1'b1;
      icache_pc_i = hit_pcs[i];
      exp_q.push_back({1'b0, word(hit_pcs[i])});
      @(negedge clk_i);
      chk("hit_accept", 64'(icache_accept_o), 64'd1);
      if (i > 0) chk("hit_valid", 64'(icache_valid_o), 64'd1);
      chk("hit_no_memreq", 64'(mem_req_o), 64'd0);
      tick();
    end
    icache_rd_i = 1'b0;
    @(negedge clk_i);
    chk("hit_valid_last", 64'(icache_valid_o), 64'd1);
    tick();
    @(negedge clk_i);
    chk("hit_no_memreq_after", 64'(mem_req_o), 64'd0);
    tick();

    // Conflict eviction on index 0.
    req(32'h8000_0800);
    refill(32'h8000_0800, -1, 1'b0);
    tick();
    req(32'h8000_0000);
    refill(32'h8000_0000, -1, 1'b0);
    tick();

    // Refill error on beat 2, then the same PC must miss again.
    req(32'h8000_0800);
    refill(32'h8000_0800, -1, 1'b0);
    tick();
    req(32'h8000_0000);
    refill(32'h8000_0000, 2, 1'b0);
    tick();
    req(32'h8000_0000);
    refill(32'h8000_0000, -1, 1'b0);

    // Flush during refill: response delivered, then 64 refused cycles.
    tick();
    req(32'h8000_0040);
    refill(32'h8000_0040, -1, 1'b1);
    count_blocked(32'h8000_0000, 64);
    refill(32'h8000_0000, -1, 1'b0);
    tick();

    // Reset in the middle of a refill.
    req(32'h8000_0800);
    wait_req(32'h8000_0800, got);
    if (got) begin
      mem_accept_i = 1'b1;
      tick();
      mem_accept_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mem_valid_i = 1'b1;
        mem_data_i  = word(32'h8000_0800 + 32'(8 * k));
        tick();
      end
      mem_valid_i = 1'b0;
    end
    rstn_i = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick();
    tick();
    rstn_i = 1'b1;
    tick();
    req(32'h8000_0000);
    refill(32'h8000_0000, -1, 1'b0);
    tick();

    // Flush coincident with a request, then wrap-around PC after the flush.
    icache_rd_i    = 1'b1;
    icache_pc_i    = 32'hFFFF_FFF8;
    icache_flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_same_cycle_accept", 64'(icache_accept_o), 64'd0);
    tick();
    icache_flush_i = 1'b0;
    count_blocked(32'hFFFF_FFF8, 64);
    refill(32'hFFFF_FFF8, -1, 1'b0);
    tick();

    repeat (3) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
